// File: rtl/tc_multi.sv
// tc_multi: multi-channel down-counting timer/counter with per-channel IRQ and bus register file.
// Optional per-channel 8-bit prescaler in ctrl[15:8] when TC_PRESCALE_EN is defined.
module tc_multi #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              we,
    input  logic [7:0]        addr,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

`ifdef TC_PRESCALE_EN
    localparam logic [15:0] CTRL_MASK = 16'hFF0F;
`else
    localparam logic [15:0] CTRL_MASK = 16'h000F;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    logic [3:0]              ch_idx;
    logic [1:0]              reg_idx;
    logic                    unused_addr_lsb;
    logic [NUM_CH-1:0][31:0] rd_word;

    assign ch_idx          = addr[7:4];
    assign reg_idx         = addr[3:2];
    assign unused_addr_lsb = ^addr[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_e           state_q, state_d;
            logic [15:0]      ctrl_q, ctrl_d, ctrl_wr;
            logic [CNT_W-1:0] preset_q, preset_d;
            logic [CNT_W-1:0] count_q, count_d;
            logic             pend_q, pend_d;
            logic             wr_hit, wr_ctrl, wr_preset, wr_clr;
            logic             auto_rld, cnt_tick;

            assign wr_hit    = sel & we & (ch_idx == 4'(gi));
            assign wr_ctrl   = wr_hit & (reg_idx == 2'd0);
            assign wr_preset = wr_hit & (reg_idx == 2'd1);
            assign wr_clr    = wr_hit & (reg_idx == 2'd3) & byteen[0] & wdata[0];

            // ctrl as it will be after this edge's bus write; CNT checks en against this
            assign ctrl_wr  = wr_ctrl ? (16'(merge_bytes(32'(ctrl_q), wdata, byteen)) & CTRL_MASK)
                                      : ctrl_q;
            assign auto_rld = (ctrl_q[2:1] == 2'b01);

`ifdef TC_PRESCALE_EN
            logic [7:0] div_q, div_d;

            assign cnt_tick = (div_q == ctrl_q[15:8]);

            always_comb begin
                div_d = 8'd0;
                if (state_q == S_CNT && !cnt_tick) div_d = div_q + 8'd1;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) div_q <= 8'd0;
                else       div_q <= div_d;
            end
`else
            assign cnt_tick = 1'b1;
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q  <= S_IDLE;
                    ctrl_q   <= '0;
                    preset_q <= '0;
                    count_q  <= '0;
                    pend_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    ctrl_q   <= ctrl_d;
                    preset_q <= preset_d;
                    count_q  <= count_d;
                    pend_q   <= pend_d;
                end
            end

            always_comb begin
                state_d = state_q;
                case (state_q)
                    S_IDLE: if (ctrl_q[0]) state_d = S_LOAD;
                    S_LOAD: state_d = (preset_q == '0) ? S_INT : S_CNT;
                    S_CNT: begin
                        if (!ctrl_wr[0])
                            state_d = S_IDLE;
                        else if (cnt_tick && count_q <= CNT_W'(1))
                            state_d = S_INT;
                    end
                    S_INT:   state_d = auto_rld ? S_LOAD : S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end

            always_comb begin
                ctrl_d   = ctrl_wr;
                preset_d = wr_preset ? CNT_W'(merge_bytes(32'(preset_q), wdata, byteen))
                                     : preset_q;
                count_d  = count_q;
                pend_d   = wr_clr ? 1'b0 : pend_q;
                case (state_q)
                    S_LOAD: count_d = preset_q;
                    S_CNT: begin
                        if (ctrl_wr[0] && cnt_tick)
                            count_d = (count_q > CNT_W'(1)) ? count_q - CNT_W'(1) : '0;
                    end
                    S_INT:  if (!auto_rld) ctrl_d[0] = 1'b0;
                    default: ;
                endcase
                // a new INT entry beats a same-edge W1C
                if (state_d == S_INT) pend_d = 1'b1;
            end

            assign irq[gi]     = pend_q & ctrl_q[3];
            assign rd_word[gi] = (reg_idx == 2'd0) ? 32'(ctrl_q)   :
                                 (reg_idx == 2'd1) ? 32'(preset_q) :
                                 (reg_idx == 2'd2) ? 32'(count_q)  : {31'd0, pend_q};
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel && ch_idx == 4'(i)) rdata = rd_word[i];
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_tc_multi.sv
// Directed-vector bench for tc_multi (NUM_CH=2, CNT_W=32); expected values are hand-derived cycle counts.
module tb_tc_multi;
    localparam int NUM_CH = 2;

    logic              clk, reset, sel, we;
    logic [7:0]        addr;
    logic [3:0]        byteen;
    logic [31:0]       wdata, rdata;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    int          n_vec, n_err;
    logic [31:0] rv;
    int          exp_cnt [8] = '{0, 0, 5, 4, 3, 2, 1, 0};

    tc_multi #(.NUM_CH(NUM_CH), .CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq),
        .irq_any(irq_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] b2w(input logic b);
        return {31'd0, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write lands on the next posedge; returns 1ns after that edge.
    task automatic wr(input int ch, input int r, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = {4'(ch), 2'(r), 2'b00}; byteen = be; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; byteen = 4'h0;
        $display("wr   ch%0d reg%0d be=%h data=%h", ch, r, be, d);
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] d);
        sel = 1'b1; we = 1'b0; addr = {4'(ch), 2'(r), 2'b00};
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 8'h0; byteen = 4'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_irq_any", b2w(irq_any), 32'h0);
        rd(0, 0, rv); check("rst_ctrl0", rv, 32'h0);
        @(negedge clk) reset = 1'b0;
        tick(1);

        // register file basics
        wr(0, 1, 32'hAABBCCDD, 4'hF);
        wr(0, 1, 32'h11223344, 4'b0101);
        rd(0, 1, rv); check("preset_byteen", rv, 32'hAA22CC44);
        wr(0, 2, 32'h55, 4'hF);
        rd(0, 2, rv); check("count_readonly", rv, 32'h0);
        wr(0, 0, 32'hFFFF_FFF0, 4'hF);
        rd(0, 0, rv);
`ifdef TC_PRESCALE_EN
        check("ctrl_unused_bits", rv, 32'h0000_FF00);
`else
        check("ctrl_unused_bits", rv, 32'h0);
`endif
        wr(0, 0, 32'h0, 4'hF);
        wr(2, 1, 32'h1234, 4'hF);
        rd(2, 1, rv); check("rd_ch_oob", rv, 32'h0);
        sel = 1'b0; we = 1'b0; addr = 8'h04;
        #1;
        check("rd_sel0", rdata, 32'h0);

        // one-shot, preset 5
        wr(0, 1, 32'd5, 4'hF);
        wr(0, 0, 32'h9, 4'hF);
        check("t1_irq_e0", b2w(irq[0]), 32'h0);
        for (int k = 1; k < 8; k++) begin
            tick(1);
            rd(0, 2, rv);
            check($sformatf("t1_cnt_e%0d", k), rv, 32'(exp_cnt[k]));
            check($sformatf("t1_irq_e%0d", k), b2w(irq[0]), (k == 7) ? 32'h1 : 32'h0);
        end
        tick(1);
        rd(0, 0, rv); check("t1_en_cleared", rv, 32'h8);
        check("t1_irq_any", b2w(irq_any), 32'h1);
        rd(0, 3, rv); check("t1_pending", rv, 32'h1);
        wr(0, 3, 32'h1, 4'hF);
        check("t1_w1c_irq", b2w(irq[0]), 32'h0);

        // auto-reload, preset 3, period 5
        wr(1, 1, 32'd3, 4'hF);
        wr(1, 0, 32'hB, 4'hF);
        tick(4); check("t2_irq_e4", b2w(irq[1]), 32'h0);
        tick(1); check("t2_irq_e5", b2w(irq[1]), 32'h1);
        check("t2_irq_any", b2w(irq_any), 32'h1);
        tick(1);
        wr(1, 3, 32'h1, 4'hF);
        check("t2_w1c_e7", b2w(irq[1]), 32'h0);
        tick(2); check("t2_irq_e9", b2w(irq[1]), 32'h0);
        tick(1); check("t2_irq_e10", b2w(irq[1]), 32'h1);
        tick(4);
        wr(1, 3, 32'h1, 4'hF);
        rd(1, 3, rv); check("t2_clr_vs_set", rv, 32'h1);
        wr(1, 0, 32'h0, 4'hF);
        wr(1, 3, 32'h1, 4'hF);
        check("t2_quiet", b2w(irq_any), 32'h0);

        // disable mid-count
        wr(0, 0, 32'h9, 4'hF);
        tick(2); rd(0, 2, rv); check("t3_cnt5", rv, 32'd5);
        tick(1); rd(0, 2, rv); check("t3_cnt4", rv, 32'd4);
        wr(0, 0, 32'h0, 4'hF);
        rd(0, 2, rv); check("t3_hold", rv, 32'd4);
        tick(10);
        rd(0, 2, rv); check("t3_hold_late", rv, 32'd4);
        rd(0, 3, rv); check("t3_no_pend", rv, 32'h0);

        // clear en on the edge that would enter INT
        wr(0, 1, 32'd2, 4'hF);
        wr(0, 0, 32'h9, 4'hF);
        tick(3); rd(0, 2, rv); check("t3b_cnt1", rv, 32'd1);
        wr(0, 0, 32'h0, 4'hF);
        tick(3);
        rd(0, 3, rv); check("t3b_no_pend", rv, 32'h0);
        rd(0, 2, rv); check("t3b_hold1", rv, 32'd1);
        check("t3b_irq", b2w(irq[0]), 32'h0);

        // preset 0 goes straight to INT
        wr(0, 1, 32'd0, 4'hF);
        wr(0, 0, 32'h9, 4'hF);
        tick(1); check("t4_irq_e1", b2w(irq[0]), 32'h0);
        tick(1); check("t4_irq_e2", b2w(irq[0]), 32'h1);
        tick(1); rd(0, 0, rv); check("t4_en_cleared", rv, 32'h8);
        wr(0, 3, 32'h1, 4'hF);
        check("t4_cleared", b2w(irq_any), 32'h0);

        // preset rewritten during CNT, auto-reload
        wr(1, 1, 32'd4, 4'hF);
        wr(1, 0, 32'hB, 4'hF);
        tick(2); rd(1, 2, rv); check("t5_cnt4", rv, 32'd4);
        wr(1, 1, 32'd7, 4'hF);
        rd(1, 2, rv); check("t5_cnt3", rv, 32'd3);
        tick(2); check("t5_irq_e5", b2w(irq[1]), 32'h0);
        tick(1); check("t5_irq_e6", b2w(irq[1]), 32'h1);
        tick(2); rd(1, 2, rv); check("t5_reload7", rv, 32'd7);

        // asynchronous reset mid-count with irq high
        #2;
        reset = 1'b1;
        #1;
        check("t6_irq", 32'(irq), 32'h0);
        check("t6_irq_any", b2w(irq_any), 32'h0);
        rd(1, 0, rv); check("t6_ctrl", rv, 32'h0);
        rd(1, 1, rv); check("t6_preset", rv, 32'h0);
        rd(1, 2, rv); check("t6_count", rv, 32'h0);
        rd(1, 3, rv); check("t6_status", rv, 32'h0);
        @(negedge clk) reset = 1'b0;
        tick(1);

`ifdef TC_PRESCALE_EN
        wr(0, 1, 32'd2, 4'hF);
        wr(0, 0, 32'h0309, 4'hF);
        tick(9);  check("p_irq_e9", b2w(irq[0]), 32'h0);
        tick(1);  check("p_irq_e10", b2w(irq[0]), 32'h1);
        tick(1);
        wr(0, 3, 32'h1, 4'hF);
`endif
        // psc = 0 (or no prescaler): preset 2 one-shot
        wr(0, 1, 32'd2, 4'hF);
        wr(0, 0, 32'h0009, 4'hF);
        tick(3); check("p0_irq_e3", b2w(irq[0]), 32'h0);
        tick(1); check("p0_irq_e4", b2w(irq[0]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
